// File: rtl/core_pipe_exec_mdu_if.sv
// rtl/core_pipe_exec_mdu_if.sv - execute-stage to multiply/divide unit request/response bundle
interface core_pipe_exec_mdu_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            mdu_valid;
  logic [2:0]      mdu_op;
  logic            mdu_word;
  logic [XLEN-1:0] mdu_opr_a;
  logic [XLEN-1:0] mdu_opr_b;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_result;
  logic            mdu_busy;

  modport master (
    output flush, mdu_valid, mdu_op, mdu_word, mdu_opr_a, mdu_opr_b,
    input  mdu_ready, mdu_result, mdu_busy
  );

  modport slave (
    input  flush, mdu_valid, mdu_op, mdu_word, mdu_opr_a, mdu_opr_b,
    output mdu_ready, mdu_result, mdu_busy
  );
endinterface

// File: rtl/core_pipe_exec_mdu.sv
// rtl/core_pipe_exec_mdu.sv - iterative RV64M/RV32M multiply/divide unit (shift-add MUL, restoring DIV)
// Optional early termination of MUL and zero-dividend DIV: CORE_MDU_EARLY_TERM_EN
module core_pipe_exec_mdu #(
  parameter int XLEN    = 64,
  parameter int MUL_BPC = 1
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  core_pipe_exec_mdu_if.slave   mdu
);

  localparam int CW = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_word;
  logic              r_neg;
  logic [XLEN-1:0]   r_hold;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = x;
    for (int i = 32; i < XLEN; i++) r[i] = x[31];
    return r;
  endfunction

  // Request decode: operands are trimmed to the operation width and signed ones made positive.
  logic            w_word;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_minneg;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_is_div;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_dvd_zero;
  logic            w_fast;
  logic            w_neg;
  logic            w_start;
  logic [CW-1:0]   w_cnt_init;

  assign w_word     = (XLEN == 64) && mdu.mdu_word;
  assign w_mask     = w_word ? XLEN'(64'hFFFF_FFFF) : '1;
  assign w_minneg   = w_word ? XLEN'(64'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_a        = mdu.mdu_opr_a & w_mask;
  assign w_b        = mdu.mdu_opr_b & w_mask;
  assign w_is_div   = mdu.mdu_op[2];
  assign w_a_signed = w_is_div ? !mdu.mdu_op[0] : (mdu.mdu_op != 3'd3);
  assign w_b_signed = w_is_div ? !mdu.mdu_op[0] : (mdu.mdu_op[1] == 1'b0);
  assign w_a_neg    = w_a_signed && (w_word ? w_a[31] : w_a[XLEN-1]);
  assign w_b_neg    = w_b_signed && (w_word ? w_b[31] : w_b[XLEN-1]);
  assign w_a_mag    = w_a_neg ? ((-w_a) & w_mask) : w_a;
  assign w_b_mag    = w_b_neg ? ((-w_b) & w_mask) : w_b;
  assign w_div_zero = (w_b == '0);
  assign w_div_ovf  = !mdu.mdu_op[0] && (w_a == w_minneg) && (w_b == w_mask);
  // Remainder follows the dividend's sign; quotient and product follow the sign difference.
  assign w_neg      = (w_is_div && mdu.mdu_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_start    = mdu.mdu_valid && !mdu.flush;
  assign w_cnt_init = w_is_div ? (w_word ? CW'(32) : CW'(XLEN))
                               : (w_word ? CW'(32 / MUL_BPC) : CW'(XLEN / MUL_BPC));

`ifdef CORE_MDU_EARLY_TERM_EN
  assign w_dvd_zero = (w_a == '0);
`else
  assign w_dvd_zero = 1'b0;
`endif

  assign w_fast = w_is_div && (w_div_zero || w_div_ovf || w_dvd_zero);

  // Multiplier step: MUL_BPC partial products folded per cycle.
  logic [2*XLEN-1:0] w_madd;
  logic              w_mul_early;

  always_comb begin
    w_madd = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (r_mplier[j]) w_madd = w_madd + (r_mcand << j);
    end
  end

`ifdef CORE_MDU_EARLY_TERM_EN
  assign w_mul_early = (r_op == 3'd0) && ((r_mplier >> MUL_BPC) == '0);
`else
  assign w_mul_early = 1'b0;
`endif

  // Divider step: dividend is left-aligned in r_quot and shifted out MSB first.
  logic [XLEN:0]   w_rsh;
  logic [XLEN:0]   w_diff;
  logic            w_qbit;

  assign w_rsh  = {r_rem, r_quot[XLEN-1]};
  assign w_diff = w_rsh - {1'b0, r_dvsr};
  assign w_qbit = !w_diff[XLEN];

  // Result fixup and selection, presented only while in DONE.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rmd;
  logic [XLEN-1:0]   w_raw;
  logic [XLEN-1:0]   w_final;
  logic              w_ready;

  assign w_prod = r_neg ? -r_acc  : r_acc;
  assign w_quo  = r_neg ? -r_quot : r_quot;
  assign w_rmd  = r_neg ? -r_rem  : r_rem;

  always_comb begin
    w_raw = '0;
    case (r_op)
      3'd0:                w_raw = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_raw = r_word ? XLEN'(w_prod[63:32]) : w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_raw = w_quo;
      default:             w_raw = w_rmd;
    endcase
    w_final = r_word ? sext32(w_raw) : w_raw;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (!w_is_div)   w_state_nxt = S_MUL;
          else if (w_fast) w_state_nxt = S_DONE;
          else             w_state_nxt = S_DIV;
        end
      end
      S_MUL: begin
        if (mdu.flush || !mdu.mdu_valid)          w_state_nxt = S_IDLE;
        else if ((r_cnt == CW'(1)) || w_mul_early) w_state_nxt = S_DONE;
      end
      S_DIV: begin
        if (mdu.flush || !mdu.mdu_valid) w_state_nxt = S_IDLE;
        else if (r_cnt == CW'(1))        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ready     = !mdu.flush;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_neg    <= 1'b0;
      r_hold   <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_start) begin
        r_op     <= mdu.mdu_op;
        r_word   <= w_word;
        r_neg    <= w_neg;
        r_cnt    <= w_cnt_init;
        r_acc    <= '0;
        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_dvsr   <= w_b_mag;
        r_rem    <= '0;
        r_quot   <= w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
        // Fast-path results are stored already final, so the sign fixup is bypassed.
        if (w_is_div && w_div_zero) begin
          r_quot <= '1;
          r_rem  <= mdu.mdu_opr_a;
          r_neg  <= 1'b0;
        end else if (w_is_div && w_div_ovf) begin
          r_quot <= mdu.mdu_opr_a;
          r_neg  <= 1'b0;
        end else if (w_is_div && w_dvd_zero) begin
          r_quot <= '0;
          r_neg  <= 1'b0;
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= r_acc + w_madd;
        r_mcand  <= r_mcand << MUL_BPC;
        r_mplier <= r_mplier >> MUL_BPC;
        r_cnt    <= r_cnt - CW'(1);
      end else if (r_state == S_DIV) begin
        r_rem    <= w_qbit ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0];
        r_quot   <= {r_quot[XLEN-2:0], w_qbit};
        r_cnt    <= r_cnt - CW'(1);
      end
      if (w_ready) r_hold <= w_final;
    end
  end

  assign mdu.mdu_ready  = w_ready;
  assign mdu.mdu_busy   = (r_state != S_IDLE);
  assign mdu.mdu_result = w_ready ? w_final : r_hold;

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// tb/tb_core_pipe_exec_mdu.sv - randomized and directed bench for core_pipe_exec_mdu against an arithmetic reference model
module tb_core_pipe_exec_mdu;
  localparam int XLEN = 64;
  localparam int BPC  = 1;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  core_pipe_exec_mdu_if #(.XLEN(XLEN)) mdu_if ();

  core_pipe_exec_mdu #(.XLEN(XLEN), .MUL_BPC(BPC)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .mdu      (mdu_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
    int           w;
    logic [63:0]  mask, aw, bw, q, rm, r;
    logic [127:0] ea_s, ea_u, eb_s, eb_u, p;
    longint       sa, sb;
    w    = word ? 32 : 64;
    mask = word ? 64'hFFFF_FFFF : '1;
    aw   = a & mask;
    bw   = b & mask;
    ea_s = word ? {{96{aw[31]}}, aw[31:0]} : {{64{aw[63]}}, aw};
    eb_s = word ? {{96{bw[31]}}, bw[31:0]} : {{64{bw[63]}}, bw};
    ea_u = {64'b0, aw};
    eb_u = {64'b0, bw};
    sa   = $signed(ea_s[63:0]);
    sb   = $signed(eb_s[63:0]);
    r    = '0;
    case (op)
      3'd0: begin p = ea_s * eb_s; r = p[63:0]; end
      3'd1: begin p = ea_s * eb_s; p = p >> w; r = p[63:0]; end
      3'd2: begin p = ea_s * eb_u; p = p >> w; r = p[63:0]; end
      3'd3: begin p = ea_u * eb_u; p = p >> w; r = p[63:0]; end
      3'd4, 3'd6: begin
        if (bw == 0) begin q = '1; rm = aw; end
        else if (ea_s[w-1] && (aw == (mask ^ (mask >> 1))) && (bw == mask)) begin q = aw; rm = 0; end
        else begin q = 64'(sa / sb); rm = 64'(sa % sb); end
        r = (op == 3'd4) ? q : rm;
      end
      default: begin
        if (bw == 0) begin q = '1; rm = aw; end
        else begin q = aw / bw; rm = aw % bw; end
        r = (op == 3'd5) ? q : rm;
      end
    endcase
    r = r & mask;
    if (word) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic word,
                                     input logic [63:0] a, input logic [63:0] b);
    int          w;
    logic [63:0] mask, aw, bw, bmag;
    int          nb, cyc;
    w    = word ? 32 : 64;
    mask = word ? 64'hFFFF_FFFF : '1;
    aw   = a & mask;
    bw   = b & mask;
    bmag = bw;
    nb   = 0;
    cyc  = 0;
    if (op < 3'd4) begin
`ifdef CORE_MDU_EARLY_TERM_EN
      if (op == 3'd0) begin
        if (bw[w-1]) bmag = (-bw) & mask;
        while (bmag != 0) begin nb++; bmag = bmag >> 1; end
        cyc = (nb + BPC - 1) / BPC;
        if (cyc < 1) cyc = 1;
        return cyc + 1;
      end
`endif
      return w / BPC + 1;
    end
    if (bw == 0) return 1;
    if (!op[0] && (aw == (mask ^ (mask >> 1))) && (bw == mask)) return 1;
`ifdef CORE_MDU_EARLY_TERM_EN
    if (aw == 0) return 1;
`endif
    return w + 1;
  endfunction

  // Caller is positioned just after a falling edge; returns just after a falling edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    bit got_rdy;
    mdu_if.mdu_op    = op;
    mdu_if.mdu_word  = word;
    mdu_if.mdu_opr_a = a;
    mdu_if.mdu_opr_b = b;
    mdu_if.mdu_valid = 1'b1;
    @(posedge g_clk);
    lat = 0;
    got_rdy = 1'b0;
    while (!got_rdy && lat < 200) begin
      @(negedge g_clk);
      lat++;
      if (lat == 1) check_eq({tag, ".busy"}, 64'(mdu_if.mdu_busy), 64'd1);
      if (mdu_if.mdu_ready) got_rdy = 1'b1;
    end
    check_eq({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, ".res"}, mdu_if.mdu_result, exp);
    mdu_if.mdu_valid = 1'b0;
    @(negedge g_clk);
    check_eq({tag, ".pulse"}, {62'b0, mdu_if.mdu_ready, mdu_if.mdu_busy}, 64'd0);
    check_eq({tag, ".hold"}, mdu_if.mdu_result, exp);
  endtask

  task automatic do_model_op(input string tag, input logic [2:0] op, input logic word,
                             input logic [63:0] a, input logic [63:0] b);
    do_op(tag, op, word, a, b, ref_result(op, word, a, b), ref_latency(op, word, a, b));
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    mdu_if.flush     = 1'b0;
    mdu_if.mdu_valid = 1'b0;
    mdu_if.mdu_op    = 3'd0;
    mdu_if.mdu_word  = 1'b0;
    mdu_if.mdu_opr_a = '0;
    mdu_if.mdu_opr_b = '0;
    #1;
    check_eq("rst.ready",  64'(mdu_if.mdu_ready), 64'd0);
    check_eq("rst.busy",   64'(mdu_if.mdu_busy),  64'd0);
    check_eq("rst.result", mdu_if.mdu_result,     64'd0);
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);

    do_op("mul_7_m3",  3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, ref_latency(3'd0, 1'b0, 64'd7, -64'sd3));
    do_op("mulhu_max", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_op("mulhsu",    3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("div_m7_2",  3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 65);
    do_op("rem_m7_2",  3'd6, 1'b0, -64'sd7, 64'd2, -64'sd1, 65);
    do_op("divu_by0",  3'd5, 1'b0, 64'd5, 64'd0, '1, 1);
    do_op("rem_ovf",   3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    do_op("div_ovf",   3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    do_op("divw",      3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);
    do_op("mulw",      3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, ref_latency(3'd0, 1'b1, 64'h1_0000, 64'h1_0000));
`ifdef CORE_MDU_EARLY_TERM_EN
    do_op("mul_et",    3'd0, 1'b0, 64'd5, 64'd1, 64'd5, 2);
    do_op("div_zd",    3'd4, 1'b0, 64'd0, 64'd9, 64'd0, 1);
`endif

    // Flush at iteration 10 of a divide, then an immediate new multiply.
    mdu_if.mdu_op    = 3'd4;
    mdu_if.mdu_word  = 1'b0;
    mdu_if.mdu_opr_a = 64'd1000;
    mdu_if.mdu_opr_b = 64'd7;
    mdu_if.mdu_valid = 1'b1;
    @(posedge g_clk);
    repeat (10) @(negedge g_clk);
    check_eq("flush.pre_busy", 64'(mdu_if.mdu_busy), 64'd1);
    mdu_if.flush = 1'b1;
    #1;
    check_eq("flush.ready_cyc", 64'(mdu_if.mdu_ready), 64'd0);
    @(negedge g_clk);
    check_eq("flush.busy",  64'(mdu_if.mdu_busy),  64'd0);
    check_eq("flush.ready", 64'(mdu_if.mdu_ready), 64'd0);
    mdu_if.flush = 1'b0;
    do_op("post_flush_mul", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, ref_latency(3'd0, 1'b0, 64'd3, 64'd4));

    // Flush together with valid in IDLE must not start anything.
    mdu_if.flush     = 1'b1;
    mdu_if.mdu_valid = 1'b1;
    @(negedge g_clk);
    check_eq("flush_idle.busy", 64'(mdu_if.mdu_busy), 64'd0);
    mdu_if.flush     = 1'b0;
    mdu_if.mdu_valid = 1'b0;
    @(negedge g_clk);

    // Asynchronous reset mid-multiply.
    mdu_if.mdu_op    = 3'd0;
    mdu_if.mdu_opr_a = 64'd11;
    mdu_if.mdu_opr_b = 64'hFFFF;
    mdu_if.mdu_valid = 1'b1;
    @(posedge g_clk);
    repeat (5) @(negedge g_clk);
    check_eq("arst.pre_busy",   64'(mdu_if.mdu_busy), 64'd1);
    check_eq("arst.pre_result", mdu_if.mdu_result,    64'd12);
    #2 g_resetn = 1'b0;
    #1;
    check_eq("arst.busy",   64'(mdu_if.mdu_busy),  64'd0);
    check_eq("arst.ready",  64'(mdu_if.mdu_ready), 64'd0);
    check_eq("arst.result", mdu_if.mdu_result,     64'd0);
    mdu_if.mdu_valid = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic        word;
      logic [63:0] a, b;
      op   = 3'($urandom_range(0, 7));
      word = 1'($urandom_range(0, 1));
      a    = rnd_val();
      b    = rnd_val();
      do_model_op($sformatf("rnd%0d_op%0d_w%0d", i, op, word), op, word, a, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
